// File: rtl/i2c_reg_master.sv
// i2c_reg_master: single-master I2C initiator for 8-bit register writes and reads.
// Write: S, {DEV_ADDR,0}, A, regAddr, A, wrData, A, P
// Read:  S, {DEV_ADDR,0}, A, regAddr, A, Sr, {DEV_ADDR,1}, A, data, NACK, P
// SCL/SDA are open-drain: the Oe outputs only ever pull low or release.
//
// Handshake: start is sampled only while busy=0. A sampled start latches rnw,
// regAddr and wrData, clears ackErr and raises busy on the next cycle. busy stays
// high until the STOP completes; that cycle drops busy and pulses done, and a
// start presented during the done cycle is accepted. start while busy is dropped.
module i2c_reg_master #(
  parameter logic [6:0] DEV_ADDR = 7'h3c,
  parameter int         SCL_QTR  = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rnw,
  input  logic [7:0] regAddr,
  input  logic [7:0] wrData,
  output logic [7:0] rdData,
  output logic       busy,
  output logic       done,
  output logic       ackErr,
  output logic       sclOe,
  output logic       sdaOe,
  input  logic       sdaIn,
  output logic [2:0] dbgState
);

  localparam int CW = $clog2(SCL_QTR);
  localparam logic [CW-1:0] QTR_LAST = CW'(SCL_QTR - 1);

  typedef enum logic [2:0] {
    IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_NACK, STOP
  } stateT;

  stateT         state, stateNext;
  logic [CW-1:0] qCnt;       // clk cycles within the current quarter
  logic [1:0]    qtr;        // quarter within the current bit slot
  logic [2:0]    bitCnt;     // bit within the current byte, MSB first
  logic [1:0]    byteIdx;    // bytes ACKed so far in this transaction
  logic [7:0]    shiftReg;   // outgoing byte (MSB on the wire) or incoming byte
  logic          rnwL;
  logic [7:0]    regL;
  logic [7:0]    dataL;
  logic          ackBit;     // SDA seen in the ACK slot; 1 means NACK
  logic          sdaMeta, sdaSync;
  logic          tick, sampleTick, slotEnd;

  assign tick       = busy && (qCnt == QTR_LAST);
  assign sampleTick = tick && (qtr == 2'd2);
  assign slotEnd    = tick && (qtr == 2'd3);
  assign dbgState   = state;

  // Two-flop synchroniser for the SDA input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sdaMeta <= 1'b1;
      sdaSync <= 1'b1;
    end else begin
      sdaMeta <= sdaIn;
      sdaSync <= sdaMeta;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state: every phase except IDLE advances only at the end of a bit slot
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:           if (start) stateNext = START;
      START, RESTART: if (slotEnd) stateNext = TX_BYTE;
      TX_BYTE:        if (slotEnd && bitCnt == 3'd7) stateNext = RX_ACK;
      RX_ACK: begin
        if (slotEnd) begin
          if (ackBit) stateNext = STOP;
          else begin
            case (byteIdx)
              2'd0:    stateNext = TX_BYTE;
              2'd1:    stateNext = rnwL ? RESTART : TX_BYTE;
              default: stateNext = rnwL ? RX_BYTE : STOP;
            endcase
          end
        end
      end
      RX_BYTE:        if (slotEnd && bitCnt == 3'd7) stateNext = TX_NACK;
      TX_NACK:        if (slotEnd) stateNext = STOP;
      STOP:           if (slotEnd) stateNext = IDLE;
      default:        stateNext = IDLE;
    endcase
  end

  // Bus line decode: SCL low in q0/q1 of data slots; START/Sr/STOP shape SDA while SCL is high
  always_comb begin
    sclOe = 1'b0;
    sdaOe = 1'b0;
    case (state)
      START: begin
        sclOe = (qtr == 2'd3);
        sdaOe = (qtr != 2'd0);
      end
      RESTART: begin
        sclOe = (qtr == 2'd0) || (qtr == 2'd3);
        sdaOe = qtr[1];
      end
      TX_BYTE: begin
        sclOe = ~qtr[1];
        sdaOe = ~shiftReg[7];
      end
      RX_ACK, RX_BYTE, TX_NACK: sclOe = ~qtr[1];
      STOP: begin
        sclOe = (qtr == 2'd0);
        sdaOe = (qtr != 2'd3);
      end
      default: ;
    endcase
  end

  // Datapath: quarter timing, byte shifting, ACK capture and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qCnt     <= '0;
      qtr      <= 2'd0;
      bitCnt   <= 3'd0;
      byteIdx  <= 2'd0;
      shiftReg <= 8'h00;
      rnwL     <= 1'b0;
      regL     <= 8'h00;
      dataL    <= 8'h00;
      ackBit   <= 1'b0;
      rdData   <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      ackErr   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        qCnt <= tick ? '0 : qCnt + 1'b1;
        if (tick) qtr <= qtr + 2'd1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            rnwL     <= rnw;
            regL     <= regAddr;
            dataL    <= wrData;
            ackErr   <= 1'b0;
            busy     <= 1'b1;
            shiftReg <= {DEV_ADDR, 1'b0};
            byteIdx  <= 2'd0;
            bitCnt   <= 3'd0;
            qCnt     <= '0;
            qtr      <= 2'd0;
          end
        end
        TX_BYTE: begin
          if (slotEnd) begin
            shiftReg <= {shiftReg[6:0], 1'b0};
            bitCnt   <= bitCnt + 3'd1;
          end
        end
        RX_ACK: begin
          if (sampleTick) ackBit <= sdaSync;
          if (slotEnd) begin
            if (ackBit) ackErr <= 1'b1;
            else begin
              byteIdx <= byteIdx + 2'd1;
              case (byteIdx)
                2'd0:    shiftReg <= regL;
                2'd1:    shiftReg <= rnwL ? {DEV_ADDR, 1'b1} : dataL;
                default: shiftReg <= 8'h00;
              endcase
            end
          end
        end
        RX_BYTE: begin
          if (sampleTick) shiftReg <= {shiftReg[6:0], sdaSync};
          if (slotEnd) begin
            bitCnt <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) rdData <= shiftReg;
          end
        end
        STOP: begin
          if (slotEnd) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
